// File: rtl/ss_pkg.sv
// Shared constants and types for the seven-segment scan driver: segment codes,
// the converter state encoding and a constant power-of-ten helper.
package ss_pkg;

    // Active-low cathodes, bit6 = a .. bit0 = g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } conv_state_e;

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/ss_scan_driver_if.sv
// Value/control inputs and display pin outputs of the scan driver, bundled so the
// counter logic (master) and the driver (slave) share one connection.
interface ss_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 17
);
    logic [BIN_WIDTH-1:0]  value_in;
    logic                  load;
    logic                  blank_lz;
    logic [NUM_DIGITS-1:0] blink_mask;
    logic [NUM_DIGITS-1:0] dp_in;
    logic [NUM_DIGITS-1:0] anode_out;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic                  busy;
    logic                  overflow;

    modport master (
        output value_in, load, blank_lz, blink_mask, dp_in,
        input  anode_out, seg_out, dp_out, busy, overflow
    );

    modport slave (
        input  value_in, load, blank_lz, blink_mask, dp_in,
        output anode_out, seg_out, dp_out, busy, overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one shift per cycle, out-of-range
// inputs are flagged up front and skip the conversion entirely.
module bin2bcd_seq
    import ss_pkg::*;
#(
    parameter int BIN_WIDTH  = 17,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    main_clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] bcd
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam longint unsigned LIMIT = pow10(NUM_DIGITS);

    conv_state_e          state;
    logic [BIN_WIDTH-1:0] shift_bin;
    logic [BCD_W-1:0]     adj_bcd;
    logic [CNT_W-1:0]     iter;
    logic                 in_range;

    assign in_range = 64'(bin) < LIMIT;

    always_comb begin
        // NOTE: every variable gets a default before the conditional updates, so no latch is inferred.
        adj_bcd = bcd;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) adj_bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
    end

    // The range check guarantees the top BCD bit is zero, so dropping it on the shift is safe.
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_bin <= '0;
            bcd       <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (in_range) begin
                            shift_bin <= bin;
                            bcd       <= '0;
                            iter      <= '0;
                            overflow  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= ST_CONV;
                        end else begin
                            overflow <= 1'b1;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_CONV: begin
                    bcd       <= BCD_W'({adj_bcd, shift_bin[BIN_WIDTH-1]});
                    shift_bin <= shift_bin << 1;
                    iter      <= iter + CNT_W'(1);
                    if (iter == CNT_W'(BIN_WIDTH - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ss_scan_driver.sv
// Multiplexed seven-segment driver: scans NUM_DIGITS digits from a BCD display
// register with leading-zero blanking, per-digit blink, decimal points and overflow dashes.
module ss_scan_driver
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 17,
    parameter int REFRESH_DIV = 262144,
    parameter int BLINK_DIV   = 50000000
) (
    input logic             main_clock,
    input logic             reset,
    ss_scan_driver_if.slave bus
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic [BCD_W-1:0]      display_bcd;
    logic [REF_W-1:0]      refresh_cnt;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  blink_on;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      rev_idx;
    logic [3:0]            digit_val [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  all_zero;
    logic [NUM_DIGITS-1:0] anode_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    bin2bcd_seq #(
        .BIN_WIDTH (BIN_WIDTH),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_conv (
        .main_clock(main_clock),
        .reset     (reset),
        .start     (bus.load),
        .bin       (bus.value_in),
        .busy      (bus.busy),
        .done      (conv_done),
        .overflow  (bus.overflow),
        .bcd       (conv_bcd)
    );

    // Only a finished conversion reaches the display, never the working register.
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) display_bcd <= '0;
        else if (conv_done) display_bcd <= conv_bcd;
    end

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
        end else begin
            if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Digit 0 is the leftmost and therefore the most significant nibble.
    always_comb begin
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) digit_val[i] = display_bcd[4*(NUM_DIGITS-1-i) +: 4];
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            all_zero   = all_zero && (digit_val[i] == 4'd0);
            lz_mask[i] = all_zero;
        end
    end

    assign rev_idx = IDX_W'(NUM_DIGITS - 1) - scan_idx;

    always_comb begin
        seg_next            = seg_decode(digit_val[scan_idx]);
        dp_next             = ~bus.dp_in[scan_idx];
        anode_next          = '1;
        anode_next[rev_idx] = 1'b0;
        if (bus.overflow) seg_next = SEG_DASH;
        else if (bus.blank_lz && lz_mask[scan_idx]) seg_next = SEG_BLANK;
        if (!blink_on && bus.blink_mask[scan_idx]) begin
            seg_next = SEG_BLANK;
            dp_next  = 1'b1;
        end
    end

    // Anode, segments and dp share one register stage so they change on the same edge.
    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            bus.anode_out <= '1;
            bus.seg_out   <= SEG_BLANK;
            bus.dp_out    <= 1'b1;
        end else begin
            bus.anode_out <= anode_next;
            bus.seg_out   <= seg_next;
            bus.dp_out    <= dp_next;
        end
    end
endmodule

// File: tb/tb_ss_scan_driver.sv
// Directed self-checking bench for ss_scan_driver with fast refresh/blink dividers.
module tb_ss_scan_driver;
    localparam int ND = 4;
    localparam int BW = 17;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SD = 7'b1111110, SB = 7'b1111111;

    logic main_clock;
    logic reset;
    int   errors;
    int   checks;

    ss_scan_driver_if #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) bus ();

    ss_scan_driver #(
        .NUM_DIGITS (ND),
        .BIN_WIDTH  (BW),
        .REFRESH_DIV(4),
        .BLINK_DIV  (64)
    ) dut (
        .main_clock(main_clock),
        .reset     (reset),
        .bus       (bus)
    );

    initial main_clock = 1'b0;
    always #5 main_clock = ~main_clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_digit(input string tag, input logic [3:0] anode_pat, input logic [6:0] exp_seg);
        int n;
        n = 0;
        @(negedge main_clock);
        while (bus.anode_out !== anode_pat && n < 64) begin
            @(negedge main_clock);
            n++;
        end
        check({tag, "_anode"}, 32'(bus.anode_out), 32'(anode_pat));
        check({tag, "_seg"}, 32'(bus.seg_out), 32'(exp_seg));
    endtask

    task automatic check_all(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        check_digit({tag, "_d0"}, 4'b0111, s0);
        check_digit({tag, "_d1"}, 4'b1011, s1);
        check_digit({tag, "_d2"}, 4'b1101, s2);
        check_digit({tag, "_d3"}, 4'b1110, s3);
    endtask

    task automatic do_load(input int v);
        bus.value_in = BW'(v);
        bus.load     = 1'b1;
        @(negedge main_clock);
        bus.load     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin
            @(negedge main_clock);
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        repeat (2) @(negedge main_clock);
    endtask

    initial begin
        int busy_cycles;
        int dark_run, full_run, seg_bad, dp_bad;
        bit in_dark, had_lit;

        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        bus.value_in   = '0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        bus.dp_in      = '0;

        repeat (3) @(negedge main_clock);
        check("rst_anode", 32'(bus.anode_out), 32'hF);
        check("rst_seg", 32'(bus.seg_out), 32'h7F);
        check("rst_dp", 32'(bus.dp_out), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b0;

        // Reset arriving mid-scan and mid-conversion, together with a load.
        repeat (6) @(negedge main_clock);
        do_load(9999);
        repeat (3) @(negedge main_clock);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset        = 1'b1;
        bus.value_in = BW'(1234);
        bus.load     = 1'b1;
        #1;
        check("midrst_anode", 32'(bus.anode_out), 32'hF);
        check("midrst_seg", 32'(bus.seg_out), 32'h7F);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge main_clock);
        bus.load = 1'b0;
        @(negedge main_clock);
        reset = 1'b0;
        repeat (2) @(negedge main_clock);
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check_all("zero", S0, S0, S0, S0);

        // 1234: busy for 17 cycles, display register changes one cycle later.
        do_load(1234);
        busy_cycles = 0;
        while (bus.busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge main_clock);
        end
        check("busy_len", 32'(busy_cycles), 32'd17);
        check("disp_before", 32'(dut.display_bcd), 32'h0000);
        @(negedge main_clock);
        check("disp_after", 32'(dut.display_bcd), 32'h1234);
        check_all("v1234", S1, S2, S3, S4);

        bus.blank_lz = 1'b1;
        do_load(42);
        wait_idle("v42");
        check_all("v42", SB, SB, S4, S2);
        do_load(0);
        wait_idle("v0");
        check_all("v0", SB, SB, SB, S0);

        do_load(10000);
        check("ovf1_flag", 32'(bus.overflow), 32'd1);
        check("ovf1_busy", 32'(bus.busy), 32'd0);
        @(negedge main_clock);
        check("ovf1_busy2", 32'(bus.busy), 32'd0);
        check_all("ovf1", SD, SD, SD, SD);
        do_load(131071);
        check("ovf2_flag", 32'(bus.overflow), 32'd1);
        check("ovf2_busy", 32'(bus.busy), 32'd0);
        @(negedge main_clock);
        check_all("ovf2", SD, SD, SD, SD);
        do_load(9999);
        check("v9999_ovf", 32'(bus.overflow), 32'd0);
        wait_idle("v9999");
        check_all("v9999", S9, S9, S9, S9);

        // A second load during the conversion must be dropped.
        do_load(5678);
        repeat (3) @(negedge main_clock);
        do_load(1111);
        wait_idle("v5678");
        check("disp_5678", 32'(dut.display_bcd), 32'h5678);
        check_all("v5678", S5, S6, S7, S8);

        // Blink on the rightmost digit (bit 3), decimal point on the third digit (bit 2).
        bus.blink_mask = 4'b1000;
        bus.dp_in      = 4'b0100;
        dark_run = 0;
        full_run = -1;
        seg_bad  = 0;
        dp_bad   = 0;
        in_dark  = 1'b0;
        had_lit  = 1'b0;
        for (int c = 0; c < 320; c++) begin
            @(negedge main_clock);
            case (bus.anode_out)
                4'b1110: begin
                    if (bus.seg_out === SB) begin
                        if (had_lit) begin
                            in_dark = 1'b1;
                            dark_run++;
                        end
                    end else begin
                        if (in_dark && full_run < 0) full_run = dark_run;
                        in_dark  = 1'b0;
                        dark_run = 0;
                        had_lit  = 1'b1;
                        if (bus.seg_out !== S8) seg_bad++;
                    end
                    if (bus.dp_out !== 1'b1) dp_bad++;
                end
                4'b1101: begin
                    if (bus.seg_out !== S7) seg_bad++;
                    if (bus.dp_out !== 1'b0) dp_bad++;
                end
                4'b1011: begin
                    if (bus.seg_out !== S6) seg_bad++;
                    if (bus.dp_out !== 1'b1) dp_bad++;
                end
                4'b0111: begin
                    if (bus.seg_out !== S5) seg_bad++;
                    if (bus.dp_out !== 1'b1) dp_bad++;
                end
                default: seg_bad++;
            endcase
        end
        check("blink_dark_samples", 32'(full_run), 32'd16);
        check("blink_seg_bad", 32'(seg_bad), 32'd0);
        check("dp_bad", 32'(dp_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
